// File: rtl/fetch_mem_stub.sv
// rtl/fetch_mem_stub.sv - fetch-side memory responder with fixed latency and address-derived lines
//
// Grants fetch requests (optionally stalled by an LFSR), returns a line whose 32-bit words
// are the byte addresses of those words, LATENCY cycles after the grant, in order.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   fetch_req_i       request valid
//   fetch_addr_i      byte address; bits below the line offset are ignored
//   fetch_gnt_o       request accepted this cycle (combinational)
//   fetch_rvalid_o    response valid, one cycle per response
//   fetch_rdata_o     response line, holds its last value while rvalid is low
//   n_gnt_o, n_resp_o wrapping grant / response counters
//   busy_o            at least one granted request not yet answered
module fetch_mem_stub #(
    parameter int          FETCH_ADDR_WIDTH = 32,
    parameter int          FETCH_DATA_WIDTH = 128,
    parameter int          LATENCY          = 2,
    parameter int          MAX_OUTSTANDING  = 2,
    parameter bit          STALL_EN         = 1'b1,
    parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        fetch_req_i,
    input  logic [FETCH_ADDR_WIDTH-1:0] fetch_addr_i,
    output logic                        fetch_gnt_o,
    output logic                        fetch_rvalid_o,
    output logic [FETCH_DATA_WIDTH-1:0] fetch_rdata_o,
    output logic [31:0]                 n_gnt_o,
    output logic [31:0]                 n_resp_o,
    output logic                        busy_o
);
    localparam int OFS = $clog2(FETCH_DATA_WIDTH / 8);
    localparam int LAW = FETCH_ADDR_WIDTH - OFS;
    localparam int NW  = FETCH_DATA_WIDTH / 32;
    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);

    logic [15:0]                 lfsr;
    logic                        stall;
    logic                        room;
    logic [OW-1:0]               outst;
    logic [LAW-1:0]              gnt_line;
    logic                        last_v;
    logic [LAW-1:0]              last_a;
    logic [FETCH_ADDR_WIDTH-1:0] last_base;
    logic [FETCH_DATA_WIDTH-1:0] line_data;
    logic                        unused_addr_bits;

    assign unused_addr_bits = ^fetch_addr_i[OFS-1:0];
    assign gnt_line         = fetch_addr_i[FETCH_ADDR_WIDTH-1:OFS];

    assign stall = STALL_EN & lfsr[0] & lfsr[1];
    // A response leaving this cycle frees its slot for a grant in the same cycle.
    assign room  = (outst < OW'(MAX_OUTSTANDING)) | fetch_rvalid_o;
    // Reset is asynchronous, so the grant is masked directly rather than relying on state.
    assign fetch_gnt_o = rst_n & fetch_req_i & ~stall & room;
    assign busy_o      = (outst != '0);

    // Fibonacci LFSR, taps 16,14,13,11 (right-shifting form).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outst    <= '0;
            n_gnt_o  <= '0;
            n_resp_o <= '0;
        end else begin
            if (fetch_gnt_o && !fetch_rvalid_o) begin
                outst <= outst + 1'b1;
            end else if (!fetch_gnt_o && fetch_rvalid_o) begin
                outst <= outst - 1'b1;
            end
            if (fetch_gnt_o) begin
                n_gnt_o <= n_gnt_o + 32'd1;
            end
            if (fetch_rvalid_o) begin
                n_resp_o <= n_resp_o + 32'd1;
            end
        end
    end

    // The output register is the last of the LATENCY stages; the ones before it only
    // carry {valid, line address}.
    generate
        if (LATENCY == 1) begin : g_direct
            assign last_v = fetch_gnt_o;
            assign last_a = gnt_line;
        end else begin : g_pipe
            logic [LATENCY-2:0] pv;
            logic [LAW-1:0]     pa [LATENCY-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pv <= '0;
                    for (int s = 0; s < LATENCY - 1; s++) begin
                        pa[s] <= '0;
                    end
                end else begin
                    pv[0] <= fetch_gnt_o;
                    pa[0] <= gnt_line;
                    for (int s = 1; s < LATENCY - 1; s++) begin
                        pv[s] <= pv[s-1];
                        pa[s] <= pa[s-1];
                    end
                end
            end

            assign last_v = pv[LATENCY-2];
            assign last_a = pa[LATENCY-2];
        end
    endgenerate

    assign last_base = {last_a, {OFS{1'b0}}};

    always_comb begin
        line_data = '0;
        for (int k = 0; k < NW; k++) begin
            line_data[32*k +: 32] = 32'(last_base) + 32'(4 * k);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_rvalid_o <= 1'b0;
            fetch_rdata_o  <= '0;
        end else begin
            fetch_rvalid_o <= last_v;
            if (last_v) begin
                fetch_rdata_o <= line_data;
            end
        end
    end
endmodule
